// File: rtl/up_sequencer_pkg.sv
// Shared types and constants for the microprocessor control sequencer.
package up_pkg;

  typedef enum logic [3:0] {
    BOOT_ADDR,
    BOOT_LOAD,
    FETCH_ADDR,
    FETCH_WAIT,
    DECODE,
    EXEC,
    MEM_WAIT,
    INT_PUSH,
    INT_VEC,
    FAULT
  } state_t;

  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_BOOT_BASE = 5'b10000;
  localparam logic [4:0] OP_FETCH     = 5'b00001;
  localparam logic [4:0] OP_LDADDR    = 5'b00010;
  localparam logic [4:0] OP_STORE     = 5'b00011;
  localparam logic [4:0] OP_BR_TAKE   = 5'b00100;
  localparam logic [4:0] OP_BR_SKIP   = 5'b00101;
  localparam logic [4:0] OP_PUSH      = 5'b00110;
  localparam logic [4:0] OP_VEC       = 5'b00111;
  localparam logic [4:0] OP_ALU_BASE  = 5'b01000;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_LOAD   = 2'b01;
  localparam logic [1:0] CLS_STORE  = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  localparam logic [2:0] RB_IDLE = 3'b100;

endpackage

// File: rtl/up_sequencer_wait_timer.sv
// Saturating 8-bit wait counter; timeout flags the cycle whose low mem_re would reach WAIT_MAX.
module up_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [7:0] cnt;
  logic [8:0] cnt_p1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 8'd1;
  end

  always_comb begin
    cnt_p1  = {1'b0, cnt} + 9'd1;
    timeout = inc && (cnt_p1 >= 9'(WAIT_MAX));
  end

endmodule

// File: rtl/up_sequencer.sv
// Control sequencer: boot register load, fetch/decode/execute loop, interrupt entry, wait-timeout fault.
module up_sequencer
  import up_pkg::*;
#(
  parameter int unsigned NUM_BOOT_REGS = 3,
  parameter int unsigned WAIT_MAX      = 15
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       int_req,
  input  logic [3:0] ir,
  input  logic       z,
  input  logic       mem_re,
  output logic [4:0] op,
  output logic       ir_we,
  output logic       pc_we,
  output logic [2:0] rb_sel,
  output logic       rb_we,
  output logic       sp_we,
  output logic       mem_we,
  output logic       ale,
  output logic       int_ack,
  output logic       fault
);

  localparam logic [3:0] K_LAST = 4'(NUM_BOOT_REGS);

  state_t     state_q, state_d;
  logic [3:0] k_q, k_d;
  logic       int_en_q, int_en_d;
  logic       in_wait, wait_inc, wait_clr, timeout;
  logic       last_load, boundary;
  logic [3:0] k_m1;

  always_comb begin
    in_wait   = (state_q == BOOT_LOAD) || (state_q == FETCH_WAIT) || (state_q == MEM_WAIT);
    last_load = (k_q == K_LAST);
    wait_inc  = in_wait && !mem_re;
    wait_clr  = !wait_inc || (state_d != state_q);
  end

  up_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .nRst    (nRst),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= BOOT_ADDR;
      k_q      <= '0;
      int_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      int_en_q <= int_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    int_en_d = int_en_q;
    boundary = 1'b0;
    case (state_q)
      BOOT_ADDR: begin
        state_d = BOOT_LOAD;
        k_d     = 4'd1;
      end
      BOOT_LOAD: begin
        if (timeout)
          state_d = FAULT;
        else if (mem_re) begin
          if (last_load) begin
            int_en_d = 1'b1;
            state_d  = FETCH_ADDR;
          end else
            k_d = k_q + 4'd1;
        end
      end
      FETCH_ADDR: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        if (timeout)     state_d = FAULT;
        else if (mem_re) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (ir[3:2] == CLS_LOAD) state_d = MEM_WAIT;
        else                     boundary = 1'b1;
      end
      MEM_WAIT: begin
        if (timeout)     state_d = FAULT;
        else if (mem_re) boundary = 1'b1;
      end
      INT_PUSH: state_d = INT_VEC;
      INT_VEC:  state_d = FETCH_ADDR;
      FAULT:    state_d = FAULT;
      default:  state_d = FAULT;
    endcase
    // int_en only re-arms once int is seen low at a boundary, so a held level cannot re-enter
    if (boundary) begin
      if (int_en_q && int_req) begin
        int_en_d = 1'b0;
        state_d  = INT_PUSH;
      end else begin
        state_d = FETCH_ADDR;
        if (!int_req) int_en_d = 1'b1;
      end
    end
  end

  always_comb begin
    op      = OP_NOP;
    rb_sel  = RB_IDLE;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rb_we   = 1'b0;
    sp_we   = 1'b0;
    mem_we  = 1'b0;
    ale     = 1'b0;
    int_ack = 1'b0;
    fault   = 1'b0;
    k_m1    = k_q - 4'd1;
    if (nRst) begin
      case (state_q)
        BOOT_ADDR: begin
          op  = OP_BOOT_BASE;
          ale = 1'b1;
        end
        BOOT_LOAD: begin
          op     = {1'b1, k_q};
          rb_sel = k_m1[2:0];
          rb_we  = mem_re;
          ale    = !last_load;
          pc_we  = last_load && mem_re;
        end
        FETCH_ADDR: begin
          op  = OP_FETCH;
          ale = 1'b1;
        end
        FETCH_WAIT: ir_we = mem_re;
        EXEC: begin
          case (ir[3:2])
            CLS_ALU: begin
              op     = OP_ALU_BASE | {3'b000, ir[1:0]};
              rb_sel = 3'b000;
              rb_we  = 1'b1;
              pc_we  = 1'b1;
            end
            CLS_LOAD: begin
              op  = OP_LDADDR;
              ale = 1'b1;
            end
            CLS_STORE: begin
              op     = OP_STORE;
              rb_sel = {1'b0, ir[1:0]};
              mem_we = 1'b1;
              pc_we  = 1'b1;
            end
            default: begin
              op    = (!ir[0] || z) ? OP_BR_TAKE : OP_BR_SKIP;
              pc_we = 1'b1;
            end
          endcase
        end
        MEM_WAIT: begin
          rb_sel = {1'b0, ir[1:0]};
          rb_we  = mem_re;
          pc_we  = mem_re;
        end
        INT_PUSH: begin
          op     = OP_PUSH;
          sp_we  = 1'b1;
          mem_we = 1'b1;
        end
        INT_VEC: begin
          op      = OP_VEC;
          pc_we   = 1'b1;
          int_ack = 1'b1;
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_up_sequencer.sv
// Directed, table-driven bench for up_sequencer (NUM_BOOT_REGS=3, WAIT_MAX=15).
module tb_up_sequencer;

  logic       clk, nRst, int_req, z, mem_re;
  logic [3:0] ir;
  logic [4:0] op;
  logic [2:0] rb_sel;
  logic       ir_we, pc_we, rb_we, sp_we, mem_we, ale, int_ack, fault;

  int n_cmp = 0;
  int n_bad = 0;

  // strobe vector order: ir_we pc_we rb_we sp_we mem_we ale int_ack fault
  localparam logic [7:0] IRW = 8'h80, PCW = 8'h40, RBW = 8'h20, SPW = 8'h10;
  localparam logic [7:0] MEMW = 8'h08, ALE = 8'h04, ACK = 8'h02, FLT = 8'h01, NONE = 8'h00;
  localparam logic [2:0] IDLE = 3'b100;

  typedef struct {
    logic       int_req;
    logic [3:0] ir;
    logic       z;
    logic       mem_re;
    logic [4:0] op;
    logic [2:0] rb;
    logic [7:0] str;
  } vec_t;

  vec_t tbl[$];

  up_sequencer #(.NUM_BOOT_REGS(3), .WAIT_MAX(15)) dut (
    .clk(clk), .nRst(nRst), .int_req(int_req), .ir(ir), .z(z), .mem_re(mem_re),
    .op(op), .ir_we(ir_we), .pc_we(pc_we), .rb_sel(rb_sel), .rb_we(rb_we),
    .sp_we(sp_we), .mem_we(mem_we), .ale(ale), .int_ack(int_ack), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i, input logic [3:0] r, input logic zz, input logic m,
                              input logic [4:0] eo, input logic [2:0] er, input logic [7:0] es);
    vec_t v;
    v.int_req = i; v.ir = r; v.z = zz; v.mem_re = m;
    v.op = eo; v.rb = er; v.str = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] eo, input logic [2:0] er,
                       input logic [7:0] es);
    logic [15:0] got, exp;
    got = {op, rb_sel, ir_we, pc_we, rb_we, sp_we, mem_we, ale, int_ack, fault};
    exp = {eo, er, es};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got op=%b rb_sel=%b strobes=%b, expected op=%b rb_sel=%b strobes=%b",
               name, got[15:11], got[10:8], got[7:0], eo, er, es);
    end
  endtask

  // entered at a falling edge; drives, checks, and returns at the next falling edge
  task automatic apply(input vec_t v, input string name);
    int_req = v.int_req; ir = v.ir; z = v.z; mem_re = v.mem_re;
    #1;
    check(name, v.op, v.rb, v.str);
    @(negedge clk);
  endtask

  initial begin
    nRst = 1'b0; int_req = 1'b0; ir = '0; z = 1'b0; mem_re = 1'b0;

    // boot, fetch-wait stall, branches, interrupt entry / no re-entry / re-arm
    tbl.push_back(mk(0, 4'b0000, 0, 1, 5'b10000, IDLE,   ALE));        // 0 BOOT_ADDR
    tbl.push_back(mk(0, 4'b0000, 0, 1, 5'b10001, 3'd0,   RBW | ALE));  // 1 load k=1
    tbl.push_back(mk(0, 4'b0000, 0, 1, 5'b10010, 3'd1,   RBW | ALE));  // 2 load k=2
    tbl.push_back(mk(0, 4'b0000, 0, 1, 5'b10011, 3'd2,   RBW | PCW));  // 3 load k=3
    tbl.push_back(mk(0, 4'b0000, 0, 0, 5'b00001, IDLE,   ALE));        // 4 FETCH_ADDR
    tbl.push_back(mk(0, 4'b0000, 0, 0, 5'b00000, IDLE,   NONE));       // 5 FETCH_WAIT
    tbl.push_back(mk(0, 4'b0000, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 5'b00000, IDLE,   IRW));        // 9 data ready
    tbl.push_back(mk(0, 4'b1101, 0, 0, 5'b00000, IDLE,   NONE));       // 10 DECODE
    tbl.push_back(mk(0, 4'b1101, 0, 0, 5'b00101, IDLE,   PCW));        // 11 bnz, z=0 skip
    tbl.push_back(mk(0, 4'b1101, 0, 1, 5'b00001, IDLE,   ALE));
    tbl.push_back(mk(0, 4'b1101, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(0, 4'b1101, 1, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b1101, 1, 0, 5'b00100, IDLE,   PCW));        // 15 z=1 take
    tbl.push_back(mk(0, 4'b1100, 0, 1, 5'b00001, IDLE,   ALE));
    tbl.push_back(mk(0, 4'b1100, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(0, 4'b1100, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b1100, 0, 0, 5'b00100, IDLE,   PCW));        // 19 unconditional
    tbl.push_back(mk(1, 4'b0010, 0, 1, 5'b00001, IDLE,   ALE));        // 20 int held
    tbl.push_back(mk(1, 4'b0010, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(1, 4'b0010, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(1, 4'b0010, 0, 0, 5'b01010, 3'd0,   RBW | PCW));  // 23 ALU
    tbl.push_back(mk(1, 4'b0010, 0, 0, 5'b00110, IDLE,   SPW | MEMW)); // 24 INT_PUSH
    tbl.push_back(mk(1, 4'b0010, 0, 0, 5'b00111, IDLE,   PCW | ACK));  // 25 INT_VEC
    tbl.push_back(mk(1, 4'b0101, 0, 1, 5'b00001, IDLE,   ALE));
    tbl.push_back(mk(1, 4'b0101, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(1, 4'b0101, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(1, 4'b0101, 0, 0, 5'b00010, IDLE,   ALE));        // 29 LOAD addr
    tbl.push_back(mk(1, 4'b0101, 0, 1, 5'b00000, 3'd1,   RBW | PCW));  // 30 no re-entry
    tbl.push_back(mk(0, 4'b1011, 0, 1, 5'b00001, IDLE,   ALE));        // 31 int drops
    tbl.push_back(mk(0, 4'b1011, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 5'b00011, 3'd3,   MEMW | PCW)); // 34 STORE re-arms
    tbl.push_back(mk(1, 4'b0001, 0, 1, 5'b00001, IDLE,   ALE));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 5'b00000, IDLE,   IRW));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 5'b00000, IDLE,   NONE));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 5'b01001, 3'd0,   RBW | PCW));  // 38 ALU
    tbl.push_back(mk(1, 4'b0001, 0, 0, 5'b00110, IDLE,   SPW | MEMW)); // 39 new entry
    tbl.push_back(mk(0, 4'b0001, 0, 0, 5'b00111, IDLE,   PCW | ACK));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 5'b00001, IDLE,   ALE));        // 41 FETCH_ADDR

    repeat (2) @(negedge clk);
    #1;
    check("reset_idle", 5'b00000, IDLE, NONE);
    @(negedge clk);
    nRst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec[%0d]", i));

    // LOAD whose data never arrives: 15 low cycles tolerated, then FAULT
    apply(mk(0, 4'b0110, 0, 1, 5'b00000, IDLE, IRW), "to_fetch_wait");
    apply(mk(0, 4'b0110, 0, 0, 5'b00000, IDLE, NONE), "to_decode");
    apply(mk(0, 4'b0110, 0, 0, 5'b00010, IDLE, ALE), "to_exec_load");
    for (int c = 1; c <= 15; c++)
      apply(mk(0, 4'b0110, 0, 0, 5'b00000, 3'd2, NONE), $sformatf("mem_wait_%0d", c));
    apply(mk(0, 4'b0110, 0, 0, 5'b00000, IDLE, FLT), "fault_set");
    for (int c = 0; c < 3; c++)
      apply(mk(0, 4'b0110, 0, 1, 5'b00000, IDLE, FLT), $sformatf("fault_sticky_%0d", c));

    nRst = 1'b0;
    #1;
    check("fault_reset", 5'b00000, IDLE, NONE);
    @(negedge clk);
    nRst = 1'b1;
    apply(mk(0, 4'b0000, 0, 1, 5'b10000, IDLE, ALE), "reboot_addr");
    apply(mk(0, 4'b0000, 0, 1, 5'b10001, 3'd0, RBW | ALE), "reboot_k1");
    apply(mk(0, 4'b0000, 0, 0, 5'b10010, 3'd1, ALE), "reboot_k2_hold");

    // reset while stalled in BOOT_LOAD(2)
    nRst = 1'b0;
    #1;
    check("midboot_reset", 5'b00000, IDLE, NONE);
    @(negedge clk);
    nRst = 1'b1;
    apply(mk(0, 4'b0000, 0, 0, 5'b10000, IDLE, ALE), "restart_addr");
    apply(mk(0, 4'b0000, 0, 0, 5'b10001, 3'd0, ALE), "restart_k1_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
